periph_bus_ctrl: RTL and testbench
==================================

PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the UART bit period in CLK cycles (50 MHz / 115200 baud).
REQ-002 Parameter GPIO_W, default 8, SHALL set the GPIO input and output width.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 CLR  in  1  SHALL be the reset, asynchronous, active-low.
REQ-005 IntorPeri  in  1  SHALL select the access target from the control unit: 0 = internal RAM, 1 = peripheral space.
REQ-006 MemWrite  in  1  SHALL be the write strobe from the control unit, one cycle per store.
REQ-007 Addr  in  32  SHALL be the byte address from the datapath; only Addr[3:2] decode peripheral registers.
REQ-008 WrData  in  32  SHALL be the store data (register B).
REQ-009 RamRdData  in  32  SHALL be the read data from the internal RAM.
REQ-010 GpioIn  in  GPIO_W  SHALL be the asynchronous external input pins.
REQ-011 RamWe  out  1  SHALL be the RAM write enable.
REQ-012 RdData  out  32  SHALL be the read data returned to the datapath.
REQ-013 GpioOut  out  GPIO_W  SHALL drive the output pins.
REQ-014 UartTx  out  1  SHALL be the serial transmit line.
REQ-015 UartBusy  out  1  SHALL be high while a frame is in progress.

Function
REQ-016 RamWe SHALL equal MemWrite & ~IntorPeri, combinationally.
REQ-017 Register map (IntorPeri=1), by Addr[3:2]: 0 GPIO_OUT (RW), 1 GPIO_IN (RO), 2 UART_TX (WO, data in bits 7:0), 3 UART_STAT (RO: bit0 busy, bit1 overrun); unused bits read 0.
REQ-018 A write with IntorPeri=1 to a RO register SHALL have no effect.
REQ-019 RdData SHALL be registered: on each edge, RdData is loaded with RamRdData when IntorPeri=0 or with the decoded register value when IntorPeri=1; 1-cycle latency, so data is valid in the MA->WB cycle.
REQ-020 GpioIn SHALL pass through a 2-flop synchronizer before GPIO_IN reads it; read latency from pin to RdData is 3 cycles.
REQ-021 The UART FSM SHALL have the states IDLE, START, DATA, STOP; UartTx = 1 in IDLE, 0 in START, the current data bit in DATA (LSB first, 8 bits), and 1 in STOP.
REQ-022 Each non-IDLE state SHALL last exactly CLKS_PER_BIT cycles, counted by a baud counter that runs from 0 to CLKS_PER_BIT-1 and then wraps.
REQ-023 Transitions: IDLE->START on a UART_TX write; START->DATA; DATA->DATA until bit index 7 completes, then DATA->STOP; STOP->IDLE.
REQ-024 A UART_TX write in IDLE SHALL latch WrData[7:0] into the shift register and set UartBusy on the next edge.
REQ-025 UartBusy SHALL be high in START, DATA and STOP, and also in the first cycle after the write is accepted.
REQ-026 A UART_TX write while busy SHALL be dropped, leave the frame in progress unchanged, and set the sticky overrun bit.
REQ-027 A UART_STAT read SHALL return overrun and clear it on the same edge.
REQ-028 If a new overrun occurs in the same cycle as that read, overrun SHALL remain 1 (set wins).
REQ-029 A UART_TX write in the cycle STOP->IDLE completes SHALL be dropped with overrun set; software must poll busy.
REQ-030 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first START cycle to the return to IDLE.

Reset
REQ-031 While CLR=0, the following SHALL apply immediately: RdData=0, GpioOut=0, synchronizer=0, UART FSM in IDLE, baud counter=0, bit index=0, shift register=0, UartTx=1, UartBusy=0, overrun=0.
REQ-032 Reset during a frame SHALL abort the frame, with UartTx returning to 1 asynchronously and no partial resumption after release.

Structure
REQ-033 Register offsets (GPIO_OUT=0, GPIO_IN=1, UART_TX=2, UART_STAT=3) and the UART state encodings SHALL live in the shared opcode/constant package header alongside the opcode definitions.
REQ-034 The UART transmitter (FSM, baud counter, shift register) SHALL be one sub-module, uart_tx, with ports CLK, CLR, Start, Data[7:0], Tx, Busy; the decode logic, registers and read mux stay in periph_bus_ctrl.

Verification (CLKS_PER_BIT=4 for bench)
REQ-035 Store with IntorPeri=0, Addr=0x10010000, WrData=0xDEADBEEF -> RamWe=1 for one cycle, GpioOut unchanged, RdData=RamRdData one cycle after access.
REQ-036 Write GPIO_OUT with 0x000000A5, then read it back -> GpioOut=0xA5 next edge; RdData=0x000000A5 one cycle after the read.
REQ-037 GpioIn set to 0x3C -> a GPIO_IN read issued 2 cycles later returns 0x0000003C on RdData.
REQ-038 Write UART_TX with 0x55 -> UartTx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 4 cycles; UartBusy high for 41 cycles; UART_STAT reads 0x1 during the frame and 0x0 after.
REQ-039 A second UART_TX write of 0xFF during the frame -> frame bits unchanged; the UART_STAT read returns 0x3 and the next read returns 0x1 (or 0x0 once the frame is done).
REQ-040 Assert CLR=0 in the middle of the DATA state -> UartTx=1, UartBusy=0, GpioOut=0 immediately; after release, line idle until a new write.

Source files
------------

// File: rtl/periph_bus_ctrl_pkg.sv
// Shared opcode and constant definitions for the core and its peripheral bus.
// Holds peripheral register offsets and UART transmitter state encodings.
package periph_bus_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        REG_GPIO_OUT  = 2'd0,
        REG_GPIO_IN   = 2'd1,
        REG_UART_TX   = 2'd2,
        REG_UART_STAT = 2'd3
    } reg_off_e;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/periph_bus_ctrl_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Ports: CLK, CLR (async active-low), Start/Data load a frame, Tx line, Busy.
module uart_tx
    import periph_bus_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       Start,
    input  logic [7:0] Data,
    output logic       Tx,
    output logic       Busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    // One-cycle gap between accepting a write and entering START.
    logic          pend_q, pend_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        pend_d  = pend_q;
        Tx      = 1'b1;
        if (state_q != UART_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            UART_IDLE: begin
                if (Start) begin
                    shift_d = Data;
                    pend_d  = 1'b1;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                Tx = 1'b0;
                if (baud_end) begin
                    state_d = UART_DATA;
                    bit_d   = '0;
                end
            end
            UART_DATA: begin
                Tx = shift_q[0];
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                Tx = 1'b1;
                if (baud_end) begin
                    state_d = UART_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
        end
    end

    assign Busy = pend_q | (state_q != UART_IDLE);

endmodule

// File: rtl/periph_bus_ctrl.sv
// Memory/peripheral bus steering: RAM write enable, GPIO, UART, registered read mux.
// Ports: CLK, CLR, IntorPeri, MemWrite, Addr, WrData, RamRdData, GpioIn in; RamWe, RdData, GpioOut, UartTx, UartBusy out.
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int GPIO_W       = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              IntorPeri,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WrData,
    input  logic [31:0]       RamRdData,
    input  logic [GPIO_W-1:0] GpioIn,
    output logic              RamWe,
    output logic [31:0]       RdData,
    output logic [GPIO_W-1:0] GpioOut,
    output logic              UartTx,
    output logic              UartBusy
);

    reg_off_e          off;
    logic [31:0]       rd_q, rd_d, reg_val;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic              ovr_q, ovr_d;
    logic              wr_tx, rd_stat, tx_start, busy;
    logic              unused_bits;

    assign off         = reg_off_e'(Addr[3:2]);
    assign unused_bits = ^{Addr[31:4], Addr[1:0], WrData};

    assign RamWe    = MemWrite & ~IntorPeri;
    assign wr_tx    = IntorPeri & MemWrite & (off == REG_UART_TX);
    assign rd_stat  = IntorPeri & ~MemWrite & (off == REG_UART_STAT);
    assign tx_start = wr_tx & ~busy;

    always_comb begin
        reg_val = '0;
        unique case (off)
            REG_GPIO_OUT:  reg_val[GPIO_W-1:0] = gpio_q;
            REG_GPIO_IN:   reg_val[GPIO_W-1:0] = sync2_q;
            REG_UART_TX:   reg_val = '0;
            REG_UART_STAT: reg_val[1:0] = {ovr_q, busy};
        endcase
    end

    always_comb begin
        rd_d   = IntorPeri ? reg_val : RamRdData;
        gpio_d = gpio_q;
        if (IntorPeri && MemWrite && off == REG_GPIO_OUT) begin
            gpio_d = WrData[GPIO_W-1:0];
        end
        // A dropped write in the same cycle as a status read keeps overrun set.
        ovr_d = ovr_q;
        if (rd_stat) begin
            ovr_d = 1'b0;
        end
        if (wr_tx && busy) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rd_q    <= '0;
            gpio_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            gpio_q  <= gpio_d;
            sync1_q <= GpioIn;
            sync2_q <= sync1_q;
            ovr_q   <= ovr_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .CLK  (CLK),
        .CLR  (CLR),
        .Start(tx_start),
        .Data (WrData[7:0]),
        .Tx   (UartTx),
        .Busy (busy)
    );

    assign RdData   = rd_q;
    assign GpioOut  = gpio_q;
    assign UartBusy = busy;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl with a 4-cycle UART bit period.
// Table of single-cycle bus vectors plus hand sequences for sync, UART and reset.
module tb_periph_bus_ctrl;

    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        IntorPeri = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WrData = '0;
    logic [31:0] RamRdData = '0;
    logic [7:0]  GpioIn = '0;
    logic        RamWe;
    logic [31:0] RdData;
    logic [7:0]  GpioOut;
    logic        UartTx;
    logic        UartBusy;

    int nvec = 0;
    int nmis = 0;

    periph_bus_ctrl #(
        .CLKS_PER_BIT(CPB),
        .GPIO_W      (8)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .IntorPeri(IntorPeri),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WrData   (WrData),
        .RamRdData(RamRdData),
        .GpioIn   (GpioIn),
        .RamWe    (RamWe),
        .RdData   (RdData),
        .GpioOut  (GpioOut),
        .UartTx   (UartTx),
        .UartBusy (UartBusy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ip;
        logic        mw;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rr;
        logic        we;
        logic [31:0] rd;
        logic [7:0]  go;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        IntorPeri = 1'b0;
        MemWrite  = 1'b0;
        Addr      = '0;
        WrData    = '0;
        RamRdData = '0;
    endtask

    task automatic stat_rd;
        IntorPeri = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'hC;
    endtask

    task automatic tx_wr(input logic [7:0] d);
        IntorPeri = 1'b1;
        MemWrite  = 1'b1;
        Addr      = 32'h8;
        WrData    = {24'h0, d};
    endtask

    // k = cycles since the write edge; START begins at k=1.
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        if (k < 1 || k > 10 * CPB) return 1'b1;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    task automatic frame(input logic [7:0] d, input int mode);
        logic        pend;
        logic [31:0] erd;
        tx_wr(d);
        tick;
        idle;
        for (int k = 0; k < 46; k++) begin
            chk($sformatf("busy m%0d k%0d", mode, k), {31'b0, UartBusy},
                {31'b0, (k <= 10 * CPB)});
            chk($sformatf("tx m%0d k%0d", mode, k), {31'b0, UartTx},
                {31'b0, exp_tx(d, k)});
            idle;
            pend = 1'b0;
            erd  = '0;
            if (mode == 0) begin
                if (k == 10) begin stat_rd; pend = 1'b1; erd = 32'h1; end
                if (k == 40) tx_wr(8'h00);
                if (k == 42) begin stat_rd; pend = 1'b1; erd = 32'h2; end
                if (k == 44) begin stat_rd; pend = 1'b1; erd = 32'h0; end
            end else begin
                if (k == 12) tx_wr(8'hFF);
                if (k == 13) begin stat_rd; pend = 1'b1; erd = 32'h3; end
                if (k == 14) begin stat_rd; pend = 1'b1; erd = 32'h1; end
                if (k == 44) begin stat_rd; pend = 1'b1; erd = 32'h0; end
            end
            tick;
            if (pend) chk($sformatf("stat m%0d k%0d", mode, k), RdData, erd);
        end
        idle;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h12345678,
                    1'b1, 32'h12345678, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h10010000, 32'h0, 32'hCAFEF00D,
                    1'b0, 32'hCAFEF00D, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h0, 32'h000000A5, 32'h11111111,
                    1'b0, 32'h0, 8'hA5};
        tbl[3]  = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h22222222,
                    1'b0, 32'h000000A5, 8'hA5};
        tbl[4]  = '{1'b1, 1'b1, 32'h4, 32'hFFFFFFFF, 32'h0,
                    1'b0, 32'h0000003C, 8'hA5};
        tbl[5]  = '{1'b1, 1'b0, 32'h4, 32'h0, 32'h0,
                    1'b0, 32'h0000003C, 8'hA5};
        tbl[6]  = '{1'b1, 1'b0, 32'hC, 32'h0, 32'h0,
                    1'b0, 32'h0, 8'hA5};
        tbl[7]  = '{1'b1, 1'b1, 32'h0, 32'hFFFFFF5A, 32'h0,
                    1'b0, 32'h000000A5, 8'h5A};
        tbl[8]  = '{1'b0, 1'b1, 32'hC, 32'h0, 32'h00000001,
                    1'b1, 32'h00000001, 8'h5A};
        tbl[9]  = '{1'b1, 1'b0, 32'h10000008, 32'h0, 32'h33333333,
                    1'b0, 32'h0, 8'h5A};
        tbl[10] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 32'h0,
                    1'b0, 32'h0000005A, 8'h5A};

        GpioIn = 8'h3C;
        #2 CLR = 1'b0;
        #1;
        chk("rst rd", RdData, 32'h0);
        chk("rst gpo", {24'h0, GpioOut}, 32'h0);
        chk("rst tx", {31'b0, UartTx}, 32'h1);
        chk("rst busy", {31'b0, UartBusy}, 32'h0);
        tick;
        tick;
        CLR = 1'b1;

        for (int i = 0; i < 11; i++) begin
            IntorPeri = tbl[i].ip;
            MemWrite  = tbl[i].mw;
            Addr      = tbl[i].a;
            WrData    = tbl[i].wd;
            RamRdData = tbl[i].rr;
            #1;
            chk($sformatf("v%0d we", i), {31'b0, RamWe}, {31'b0, tbl[i].we});
            tick;
            chk($sformatf("v%0d rd", i), RdData, tbl[i].rd);
            chk($sformatf("v%0d gpo", i), {24'h0, GpioOut}, {24'h0, tbl[i].go});
        end
        idle;
        tick;

        // Pin change seen by a GPIO_IN read only from the third edge on.
        GpioIn    = 8'hC3;
        IntorPeri = 1'b1;
        Addr      = 32'h4;
        tick;
        chk("sync e1", RdData, 32'h3C);
        tick;
        chk("sync e2", RdData, 32'h3C);
        tick;
        chk("sync e3", RdData, 32'hC3);
        idle;
        tick;

        frame(8'h55, 0);
        frame(8'hA3, 1);

        // Reset in the middle of DATA.
        IntorPeri = 1'b1;
        MemWrite  = 1'b1;
        Addr      = 32'h0;
        WrData    = 32'h77;
        tick;
        tx_wr(8'h0F);
        tick;
        idle;
        for (int k = 0; k < 22; k++) tick;
        chk("pre-rst tx", {31'b0, UartTx}, 32'h0);
        chk("pre-rst gpo", {24'h0, GpioOut}, 32'h77);
        #2 CLR = 1'b0;
        #1;
        chk("mid-rst tx", {31'b0, UartTx}, 32'h1);
        chk("mid-rst busy", {31'b0, UartBusy}, 32'h0);
        chk("mid-rst gpo", {24'h0, GpioOut}, 32'h0);
        chk("mid-rst rd", RdData, 32'h0);
        tick;
        tick;
        CLR = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick;
            chk($sformatf("post-rst tx %0d", k), {31'b0, UartTx}, 32'h1);
            chk($sformatf("post-rst busy %0d", k), {31'b0, UartBusy}, 32'h0);
        end
        tx_wr(8'h81);
        tick;
        idle;
        chk("new wr busy", {31'b0, UartBusy}, 32'h1);
        chk("new wr tx", {31'b0, UartTx}, 32'h1);
        tick;
        chk("new start tx", {31'b0, UartTx}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
